// File: rtl/tt_io_bist.sv
// Loopback self-test: sends a pattern burst on tx_data and checks rx_data against a LAT-delayed copy.
// Latency: beat i leaves at cycle k+1+i, is compared at k+1+i+LAT, and done pulses LAT+1 cycles after the last beat.
// Backpressure: the data path has none; ena=0 freezes every register, so all outputs hold and no compare happens.
module tt_io_bist #(
  parameter int              WIDTH = 8,
  parameter int              LAT   = 1,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(8'hB8),
  parameter int              LEN_W = 8,
  parameter int              ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] burst_len,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [LEN_W-1:0] first_err_idx
);

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;
  logic [DW-1:0]    drn;

  // Expected-data pipe: a copy of what was sent, aged LAT cycles.
  logic             pipe_vld [LAT];
  logic [WIDTH-1:0] pipe_dat [LAT];
  logic [LEN_W-1:0] pipe_idx [LAT];

  logic             go;
  logic             last_beat;
  logic             drain_end;
  logic             mism;
  logic [WIDTH-1:0] beat0;
  logic [WIDTH-1:0] beat_nxt;
  logic [ERR_W-1:0] err_nxt;

  assign go        = ena && start && (state == S_IDLE);
  assign last_beat = (idx == len_q - LEN_W'(1));
  assign drain_end = (drn == DW'(LAT - 1));
  assign mism      = ena && pipe_vld[LAT-1] && (rx_data != pipe_dat[LAT-1]);
  assign err_nxt   = (mism && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;

  // First beat from the live inputs; PRBS never starts from the all-zero lock-up state.
  always_comb begin
    beat0 = seed;
    case (mode)
      2'd0:    beat0 = (seed == '0) ? WIDTH'(1) : seed;
      2'd2:    beat0 = WIDTH'(1);
      default: beat0 = seed;
    endcase
  end

  // Following beat derived from the current one and the latched mode.
  always_comb begin
    beat_nxt = tx_data;
    case (mode_q)
      2'd0:    beat_nxt = tx_data[0] ? ((tx_data >> 1) ^ POLY) : (tx_data >> 1);
      2'd1:    beat_nxt = tx_data + WIDTH'(1);
      2'd2:    beat_nxt = {tx_data[WIDTH-2:0], tx_data[WIDTH-1]};
      default: beat_nxt = tx_data;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    tx_valid  = (state == S_RUN);
    case (state)
      S_IDLE:  if (go) state_nxt = (burst_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (ena && last_beat) state_nxt = S_DRAIN;
      S_DRAIN: if (ena && drain_end) state_nxt = S_DONE;
      S_DONE:  if (ena) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pattern generator, beat index, drain timer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= '0;
      len_q         <= '0;
      idx           <= '0;
      drn           <= '0;
      tx_data       <= '0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else if (ena) begin
      if (mism) begin
        err_cnt <= err_nxt;
        if (err_cnt == '0) first_err_idx <= pipe_idx[LAT-1];
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q        <= mode;
            len_q         <= burst_len;
            idx           <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            pass          <= (burst_len == '0);
            if (burst_len != '0) tx_data <= beat0;
          end
        end
        S_RUN: begin
          drn <= '0;
          if (!last_beat) begin
            idx     <= idx + LEN_W'(1);
            tx_data <= beat_nxt;
          end
        end
        S_DRAIN: begin
          drn <= drn + DW'(1);
          if (drain_end) pass <= (err_nxt == '0);
        end
        default: ;
      endcase
    end
  end

  // Expected pipe shifts only while enabled so it stays aligned with the loopback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < LAT; j++) begin
        pipe_vld[j] <= 1'b0;
        pipe_dat[j] <= '0;
        pipe_idx[j] <= '0;
      end
    end else if (ena) begin
      pipe_vld[0] <= tx_valid;
      pipe_dat[0] <= tx_data;
      pipe_idx[0] <= idx;
      for (int j = 1; j < LAT; j++) begin
        pipe_vld[j] <= pipe_vld[j-1];
        pipe_dat[j] <= pipe_dat[j-1];
        pipe_idx[j] <= pipe_idx[j-1];
      end
    end
  end

endmodule

// File: tb/tb_tt_io_bist.sv
// Bench for tt_io_bist: two instances (LAT=1/ERR_W=8 and LAT=3/ERR_W=4) share stimulus.
// Each has its own ena-gated loopback line with optional beat corruption or stuck-at-zero.
// A burst-level model predicts every output, checked each cycle, plus literal expectations.
module tb_tt_io_bist;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] seed = 8'd0;
  logic [7:0] burst_len = 8'd0;
  logic [7:0] tx1, tx3, rx1, rx3, fe1, fe3, err1;
  logic [3:0] err3;
  logic       tv1, tv3, busy1, busy3, done1, done3, pass1, pass3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tt_io_bist #(.LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode), .seed(seed),
    .burst_len(burst_len), .tx_data(tx1), .tx_valid(tv1), .rx_data(rx1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(err1), .first_err_idx(fe1));

  tt_io_bist #(.LAT(3), .ERR_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode), .seed(seed),
    .burst_len(burst_len), .tx_data(tx3), .tx_valid(tv3), .rx_data(rx3), .busy(busy3),
    .done(done3), .pass(pass3), .err_cnt(err3), .first_err_idx(fe3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- loopback channel ----------------
  int         cor_idx = -1;
  logic [7:0] cor_mask = 8'h00;
  logic       stuck = 1'b0;
  logic       lv [2][3];
  logic [7:0] ld [2][3];
  int         lt [2][3];
  int         bcnt [2];

  // Loopback delay lines advance with ena, tagging each beat with its index.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        bcnt[k] <= 0;
        for (int s = 0; s < 3; s++) begin
          lv[k][s] <= 1'b0;
          ld[k][s] <= 8'h00;
          lt[k][s] <= 0;
        end
      end
    end else if (ena) begin
      lv[0][0] <= tv1; ld[0][0] <= tx1; lt[0][0] <= bcnt[0];
      lv[1][0] <= tv3; ld[1][0] <= tx3; lt[1][0] <= bcnt[1];
      bcnt[0] <= tv1 ? bcnt[0] + 1 : 0;
      bcnt[1] <= tv3 ? bcnt[1] + 1 : 0;
      for (int k = 0; k < 2; k++)
        for (int s = 1; s < 3; s++) begin
          lv[k][s] <= lv[k][s-1];
          ld[k][s] <= ld[k][s-1];
          lt[k][s] <= lt[k][s-1];
        end
    end
  end

  function automatic logic [7:0] lb(input logic v, input logic [7:0] d, input int tg,
                                    input logic stk, input int ci, input logic [7:0] cm);
    if (stk) return 8'h00;
    return (v && tg == ci) ? (d ^ cm) : d;
  endfunction

  assign rx1 = lb(lv[0][0], ld[0][0], lt[0][0], stuck, cor_idx, cor_mask);
  assign rx3 = lb(lv[1][2], ld[1][2], lt[1][2], stuck, cor_idx, cor_mask);

  // ---------------- behavioural model ----------------
  bit         act [2];
  int         t [2];
  int         n [2];
  int         merr [2];
  int         mfirst [2];
  bit         mpass [2];
  logic [7:0] mtx [2] = '{8'h00, 8'h00};
  logic [7:0] beats [256];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction
  function automatic int sat_of(input int k);
    return (k == 0) ? 255 : 15;
  endfunction
  function automatic int dtm(input int k);
    return (n[k] == 0) ? 1 : n[k] + lat_of(k) + 1;
  endfunction

  // Model: t counts enabled cycles since the start edge; beats are precomputed per burst.
  always @(posedge clk or negedge rst_n) begin : mdl
    int         i;
    logic [7:0] r;
    logic [7:0] x;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        act[k] = 0; merr[k] = 0; mfirst[k] = 0; mpass[k] = 0; mtx[k] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        r = (k == 0) ? rx1 : rx3;
        if (act[k]) begin
          if (ena) begin
            i = t[k] - 1 - lat_of(k);
            if (i >= 0 && i < n[k] && r != beats[i]) begin
              if (merr[k] == 0) mfirst[k] = i;
              if (merr[k] < sat_of(k)) merr[k]++;
            end
            if (t[k] == dtm(k)) act[k] = 0;
            else begin
              t[k]++;
              if (t[k] == dtm(k)) mpass[k] = (merr[k] == 0);
            end
          end
        end else if (ena && start) begin
          act[k] = 1; t[k] = 1; n[k] = int'(burst_len);
          merr[k] = 0; mfirst[k] = 0; mpass[k] = (n[k] == 0);
          if (k == 0) begin
            x = (mode == 2'd0 && seed == 8'h00) ? 8'h01 : seed;
            for (int j = 0; j < 256; j++) begin
              case (mode)
                2'd0: beats[j] = (j == 0) ? x
                               : ({1'b0, beats[j-1][7:1]} ^ (beats[j-1][0] ? 8'hB8 : 8'h00));
                2'd1: beats[j] = seed + 8'(j);
                2'd2: beats[j] = 8'h01 << (j % 8);
                default: beats[j] = seed;
              endcase
            end
          end
        end
        if (act[k] && n[k] > 0) mtx[k] = beats[((t[k] < n[k]) ? t[k] : n[k]) - 1];
      end
    end
  end

  // Per-cycle compare of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy1",  busy1, act[0]);
    chk("done1",  done1, act[0] && t[0] == dtm(0));
    chk("tvld1",  tv1,   act[0] && t[0] <= n[0]);
    chk("tx1",    tx1,   mtx[0]);
    chk("pass1",  pass1, mpass[0]);
    chk("err1",   err1,  merr[0]);
    chk("first1", fe1,   mfirst[0]);
    chk("busy3",  busy3, act[1]);
    chk("done3",  done3, act[1] && t[1] == dtm(1));
    chk("tvld3",  tv3,   act[1] && t[1] <= n[1]);
    chk("tx3",    tx3,   mtx[1]);
    chk("pass3",  pass3, mpass[1]);
    chk("err3",   err3,  merr[1]);
    chk("first3", fe3,   mfirst[1]);
  end

  // ---------------- stimulus ----------------
  bit         rand_ena = 0;
  logic [7:0] txq [$];

  always @(negedge clk) if (rand_ena) ena = ($urandom_range(3) != 0);

  task automatic run_burst(input logic [1:0] m, input logic [7:0] s, input logic [7:0] l,
                           input int restart_at, input int ena_off_at,
                           output int dc1, output int dc3);
    int nc;
    bit acc;
    dc1 = -1; dc3 = -1; nc = 0; acc = 0;
    txq.delete();
    @(negedge clk);
    mode = m; seed = s; burst_len = l; start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!acc && busy1) acc = 1;
      if (acc) begin
        nc++;
        start = (nc == restart_at);
        if (ena_off_at > 0) ena = !(nc >= ena_off_at && nc < ena_off_at + 5);
        if (tv1) txq.push_back(tx1);
        if (done1 && dc1 < 0) dc1 = nc;
        if (done3 && dc3 < 0) dc3 = nc;
        if (dc1 >= 0 && dc3 >= 0 && !busy1 && !busy3) break;
      end
    end
    start = 1'b0;
    chk("burst_end", {dc1 >= 0, dc3 >= 0, !busy1, !busy3}, 4'hF);
  endtask

  initial begin : main
    int d1, d3, seen;
    logic [1:0] m;
    logic [7:0] l;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    ena = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", busy1, 1'b0);
    chk("idle_tvld", tv1, 1'b0);
    chk("idle_tx", tx1, 8'h00);
    chk("idle_err", err1, 8'h00);
    chk("idle_pass", pass1, 1'b0);

    // Counter from FE wraps through zero.
    run_burst(2'd1, 8'hFE, 8'd4, 0, 0, d1, d3);
    chk("cnt_done1", d1, 6);
    chk("cnt_done3", d3, 8);
    chk("cnt_nbeats", txq.size(), 4);
    if (txq.size() == 4) begin
      chk("cnt_b0", txq[0], 8'hFE);
      chk("cnt_b1", txq[1], 8'hFF);
      chk("cnt_b2", txq[2], 8'h00);
      chk("cnt_b3", txq[3], 8'h01);
    end
    chk("cnt_pass", pass1, 1'b1);
    chk("cnt_err", err1, 8'h00);

    // PRBS from seed 0 with beat 3 corrupted.
    cor_idx = 3; cor_mask = 8'h01;
    run_burst(2'd0, 8'h00, 8'd8, 0, 0, d1, d3);
    cor_idx = -1;
    chk("prbs_nbeats", txq.size(), 8);
    if (txq.size() == 8) begin
      chk("prbs_b0", txq[0], 8'h01);
      chk("prbs_b3", txq[3], 8'h2E);
    end
    chk("prbs_err1", err1, 8'd1);
    chk("prbs_first1", fe1, 8'd3);
    chk("prbs_pass1", pass1, 1'b0);
    chk("prbs_err3", err3, 4'd1);

    // Walking one into a stuck-at-zero channel.
    stuck = 1'b1;
    run_burst(2'd2, 8'h00, 8'd10, 0, 0, d1, d3);
    chk("walk_err3", err3, 4'd10);
    chk("walk_first3", fe3, 8'd0);
    chk("walk_done3", d3, 14);
    chk("walk_pass3", pass3, 1'b0);
    run_burst(2'd2, 8'h00, 8'd20, 0, 0, d1, d3);
    chk("sat_err3", err3, 4'hF);
    chk("sat_err1", err1, 8'd20);
    run_burst(2'd1, 8'h01, 8'd255, 0, 0, d1, d3);
    chk("max_err1", err1, 8'd255);
    chk("max_done1", d1, 257);
    stuck = 1'b0;

    // Empty burst.
    run_burst(2'd3, 8'h5A, 8'd0, 0, 0, d1, d3);
    chk("empty_done1", d1, 1);
    chk("empty_done3", d3, 1);
    chk("empty_pass", pass1, 1'b1);

    // Start during RUN is ignored.
    run_burst(2'd3, 8'hA5, 8'd6, 3, 0, d1, d3);
    chk("restart_done1", d1, 8);
    chk("restart_pass", pass1, 1'b1);

    // Five frozen cycles mid-burst.
    run_burst(2'd1, 8'h30, 8'd10, 0, 4, d1, d3);
    chk("freeze_done1", d1, 17);
    chk("freeze_done3", d3, 19);
    chk("freeze_pass", pass1, 1'b1);
    ena = 1'b1;

    // Reset while beat 2 is on the wire.
    @(negedge clk);
    mode = 2'd1; seed = 8'h10; burst_len = 8'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_beat2", tx1, 8'h12);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_tx", tx1, 8'h00);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done1 || done3) seen++;
    end
    chk("rst_no_done", seen, 0);

    // Randomised bursts with random ena gaps and channel faults.
    rand_ena = 1;
    for (int b = 0; b < 40; b++) begin
      m = 2'($urandom_range(3));
      l = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(24, 1));
      cor_idx  = ($urandom_range(3) == 0) ? int'($urandom_range(int'(l), 0)) : -1;
      cor_mask = 8'($urandom_range(255, 1));
      stuck    = ($urandom_range(9) == 0);
      run_burst(m, 8'($urandom), l, 0, 0, d1, d3);
    end
    rand_ena = 0;
    ena = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
